encoder_8to3: RTL and testbench

- Registered 8-to-3 binary encoder with one-hot-violation detection.
- Eight discrete request lines d0..d7 are encoded to a 3-bit index a (MSB), b, c (LSB).
- A valid flag separates "d0 asserted" from "nothing asserted".
- Used wherever a one-hot select or request vector must be compressed to a binary index, with outputs registered for clean timing into downstream logic.

---
 rtl/encoder_8to3.sv | 68 ++++++
 tb/tb_encoder_8to3.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid and one-hot-violation flags.
// HIGH_PRIORITY selects whether the highest (1) or lowest (0) asserted index wins.
module encoder_8to3 #(
  parameter bit HIGH_PRIORITY = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  output logic a,
  output logic b,
  output logic c,
  output logic valid,
  output logic multi
);

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  logic [NUM_REQ-1:0] req_c;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               valid_d, valid_q;
  logic               multi_d, multi_q;

  assign req_c = {d7, d6, d5, d4, d3, d2, d1, d0};

  // Priority encode; the last match in scan order wins.
  always_comb begin
    idx_d   = '0;
    valid_d = |req_c;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_d = |(req_c & (req_c - NUM_REQ'(1)));
    if (HIGH_PRIORITY) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_c[i]) idx_d = IDX_W'(i);
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_c[i]) idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign a     = idx_q[2];
  assign b     = idx_q[1];
  assign c     = idx_q[0];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed bench for encoder_8to3: one instance per priority setting, shared inputs.
// Observed words are packed as {multi, valid, a, b, c}.
module tb_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;

  logic hi_a, hi_b, hi_c, hi_valid, hi_multi;
  logic lo_a, lo_b, lo_c, lo_valid, lo_multi;

  int unsigned n_vec;
  int unsigned n_err;

  encoder_8to3 #(.HIGH_PRIORITY(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .a(hi_a), .b(hi_b), .c(hi_c), .valid(hi_valid), .multi(hi_multi)
  );

  encoder_8to3 #(.HIGH_PRIORITY(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .a(lo_a), .b(lo_b), .c(lo_c), .valid(lo_valid), .multi(lo_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs_hi();
    return {hi_multi, hi_valid, hi_a, hi_b, hi_c};
  endfunction

  function automatic logic [4:0] obs_lo();
    return {lo_multi, lo_valid, lo_a, lo_b, lo_c};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05b expected %05b", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic [7:0] vec);
    @(negedge clk);
    d = vec;
    @(posedge clk);
    #1;
  endtask

  // Directed multi-hot vectors: input, expected high-priority word, expected low-priority word.
  typedef struct {
    logic [7:0] vec;
    logic [4:0] exp_hi;
    logic [4:0] exp_lo;
  } vec_t;

  vec_t tbl[5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    d     = 8'h00;

    tbl[0] = '{8'b0010_1000, 5'b11_101, 5'b11_011};  // d3+d5
    tbl[1] = '{8'b1111_1111, 5'b11_111, 5'b11_000};  // all eight
    tbl[2] = '{8'b1000_0001, 5'b11_111, 5'b11_000};  // d0+d7
    tbl[3] = '{8'b0000_0110, 5'b11_010, 5'b11_001};  // d1+d2
    tbl[4] = '{8'b0101_0000, 5'b11_110, 5'b11_100};  // d4+d6

    #3;
    check("reset_hi", obs_hi(), 5'b00_000);
    check("reset_lo", obs_lo(), 5'b00_000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_hi", obs_hi(), 5'b00_000);
    check("idle_lo", obs_lo(), 5'b00_000);

    // Single d3: no change before the edge, then 011 after it.
    @(negedge clk);
    d = 8'b0000_1000;
    #1;
    check("d3_pre_edge", obs_hi(), 5'b00_000);
    @(posedge clk);
    #1;
    check("d3_hi", obs_hi(), 5'b01_011);
    check("d3_lo", obs_lo(), 5'b01_011);

    // Walking one: index i, valid=1, multi=0 for both priorities.
    for (int i = 0; i < 8; i++) begin
      apply(8'(1) << i);
      check($sformatf("walk%0d_hi", i), obs_hi(), {2'b01, 3'(i)});
      check($sformatf("walk%0d_lo", i), obs_lo(), {2'b01, 3'(i)});
    end

    for (int i = 0; i < 5; i++) begin
      apply(tbl[i].vec);
      check($sformatf("multi%0d_hi", i), obs_hi(), tbl[i].exp_hi);
      check($sformatf("multi%0d_lo", i), obs_lo(), tbl[i].exp_lo);
    end

    // Fresh sampling: dropping all requests clears the outputs.
    apply(8'h00);
    check("drop_hi", obs_hi(), 5'b00_000);
    check("drop_lo", obs_lo(), 5'b00_000);

    // Asynchronous reset between edges with d7 held.
    apply(8'b1000_0000);
    check("d7_hi", obs_hi(), 5'b01_111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hi", obs_hi(), 5'b00_000);
    check("async_rst_lo", obs_lo(), 5'b00_000);
    @(posedge clk);
    #1;
    check("held_rst_hi", obs_hi(), 5'b00_000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_pre_edge", obs_hi(), 5'b00_000);
    @(posedge clk);
    #1;
    check("resume_hi", obs_hi(), 5'b01_111);
    check("resume_lo", obs_lo(), 5'b01_111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
